cell_pos_stream_reader: RTL

//  Read-side client of one position cell memory (2-cycle-latency single-port RAM).
//  On start: reads word 0 (particle count), then streams words 1..count out as a valid/ready stream.

---
 rtl/cell_pos_stream_reader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cell_pos_stream_reader.sv
// Streams particle positions out of one cell RAM: word 0 holds the count,
// words 1..count go out as a valid/ready stream through a credit-limited FIFO.
module cell_pos_stream_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_cnt,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_rden,
    output logic                  ram_wren,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, DONE} state_t;

    // kind: 0 = count word, 1 = position word
    typedef struct packed {
        logic                  kind;
        logic [ADDR_WIDTH-1:0] addr;
    } rd_tag_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] index;
        logic                  last;
    } fifo_ent_t;

    state_t state, state_n;

    logic    [RD_LATENCY-1:0] vld_pipe;
    rd_tag_t [RD_LATENCY-1:0] tag_pipe;
    rd_tag_t                  tail;
    logic                     tail_vld, tail_cnt, push, pop;

    logic [ADDR_WIDTH-1:0] inflight, next_addr, last_addr, cnt_q;
    logic [ADDR_WIDTH-1:0] q_cnt, cnt_clamped, issue_addr;
    logic                  issue, issue_kind, credit_ok;
    logic [SUM_W-1:0]      credit_sum;

    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    fifo_ent_t        fifo_mem [FIFO_DEPTH];
    fifo_ent_t        head, push_ent;

    assign tail     = tag_pipe[RD_LATENCY-1];
    assign tail_vld = vld_pipe[RD_LATENCY-1];
    assign tail_cnt = tail_vld && !tail.kind;
    assign push     = tail_vld && tail.kind;
    assign pop      = out_valid && out_ready;

    assign q_cnt       = ram_q[ADDR_WIDTH-1:0];
    assign cnt_clamped = (q_cnt > MAX_CNT) ? MAX_CNT : q_cnt;

    // Reads in flight plus words already queued may never exceed the FIFO,
    // so every returning word has a guaranteed slot even under full stall.
    assign credit_sum = SUM_W'(inflight) + SUM_W'(fifo_count);
    assign credit_ok  = credit_sum < SUM_W'(FIFO_DEPTH);

    always_comb begin
        state_n    = state;
        issue      = 1'b0;
        issue_kind = 1'b0;
        issue_addr = next_addr;
        case (state)
            IDLE:     if (start) state_n = CNT_RD;
            CNT_RD: begin
                issue      = 1'b1;
                issue_addr = '0;
                state_n    = CNT_WAIT;
            end
            CNT_WAIT: if (tail_cnt) state_n = (cnt_clamped == '0) ? DONE : STREAM;
            STREAM: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    issue_kind = 1'b1;
                    if (next_addr == cnt_q) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0 &&
                    (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)))
                    state_n = DONE;
            end
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Read tracker: tags travel alongside the RAM pipeline and meet ram_q at the tail.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            inflight <= '0;
        end else begin
            vld_pipe[0] <= issue;
            tag_pipe[0] <= '{kind: issue_kind, addr: issue_addr};
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
            inflight <= inflight + ADDR_WIDTH'(issue) - ADDR_WIDTH'(tail_vld);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            next_addr <= '0;
            last_addr <= '0;
            cnt_q     <= '0;
        end else begin
            if (issue) last_addr <= issue_addr;
            if (state == CNT_WAIT && tail_cnt) begin
                cnt_q     <= cnt_clamped;
                next_addr <= ADDR_WIDTH'(1);
            end else if (state == STREAM && issue) begin
                next_addr <= next_addr + ADDR_WIDTH'(1);
            end
        end
    end

    assign push_ent = '{data: ram_q, index: tail.addr, last: (tail.addr == cnt_q)};

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assert property (@(posedge clock) disable iff (rst)
        !(push && !pop && fifo_count == CNT_W'(FIFO_DEPTH)));

    assign head      = fifo_mem[rd_ptr];
    assign out_valid = (fifo_count != '0);
    // Head fields are gated so nothing undefined leaks out while empty.
    assign out_data  = out_valid ? head.data  : '0;
    assign out_index = out_valid ? head.index : '0;
    assign out_last  = out_valid ? head.last  : 1'b0;

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign particle_cnt = cnt_q;
    assign ram_rden     = issue;
    assign ram_address  = issue ? issue_addr : last_addr;
    assign ram_wren     = 1'b0;
    assign ram_data     = '0;

endmodule
